// File: rtl/sa_axil_controller.sv
// AXI4-Lite slave front-end for the systolic array: decodes each access to the scratchpad or the
// CSR bank (operand bases, dimensions, start/status) and tracks the matmul busy/done handshake.
module sa_axil_controller #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SC_ADDR_W = 16,
  parameter int DIM_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 awvalid,
  input  logic [ADDR_W-1:0]    awaddr,
  output logic                 awready,
  input  logic                 wvalid,
  input  logic [DATA_W-1:0]    wdata,
  output logic                 wready,
  output logic                 bvalid,
  output logic [1:0]           bresp,
  input  logic                 bready,
  input  logic                 arvalid,
  input  logic [ADDR_W-1:0]    araddr,
  output logic                 arready,
  output logic                 rvalid,
  output logic [DATA_W-1:0]    rdata,
  output logic [1:0]           rresp,
  input  logic                 rready,
  output logic                 sc_req,
  output logic                 sc_we,
  output logic [SC_ADDR_W-1:0] sc_addr,
  output logic [DATA_W-1:0]    sc_wdata,
  input  logic [DATA_W-1:0]    sc_rdata,
  input  logic                 sc_ready,
  output logic                 start_matmul,
  output logic [ADDR_W-1:0]    input_addr,
  output logic [ADDR_W-1:0]    weight_addr,
  output logic [ADDR_W-1:0]    output_addr,
  output logic [DIM_W-1:0]     dim_m,
  output logic [DIM_W-1:0]     dim_k,
  output logic [DIM_W-1:0]     dim_n,
  input  logic                 matmul_finished
);

  typedef enum logic [2:0] {IDLE, SC_WR, SC_RD, BRESP, RRESP} state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [3:0] CSR_INPUT  = 4'h0;
  localparam logic [3:0] CSR_WEIGHT = 4'h1;
  localparam logic [3:0] CSR_OUTPUT = 4'h2;
  localparam logic [3:0] CSR_DIMS   = 4'h3;
  localparam logic [3:0] CSR_CTRL   = 4'h4;
  localparam logic [3:0] CSR_STATUS = 4'h5;

  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                last_wr_q, last_wr_d;
  logic                awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                sc_req_q, sc_req_d, sc_we_q, sc_we_d;
  logic                start_q, start_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]   input_addr_q, input_addr_d, weight_addr_q, weight_addr_d;
  logic [ADDR_W-1:0]   output_addr_q, output_addr_d;
  logic [DIM_W-1:0]    dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;

  logic       wr_go, rd_go, pick_wr, done_set, done_clr;
  logic [3:0] wr_off, rd_off;
  logic       unused_addr_bits;

  assign wr_off = aw_addr_q[3:0];
  assign rd_off = ar_addr_q[3:0];
  assign unused_addr_bits = ^{aw_addr_q[ADDR_W-2:SC_ADDR_W], ar_addr_q[ADDR_W-2:SC_ADDR_W]};

  always_comb begin
    state_d       = state_q;
    aw_held_d     = aw_held_q;
    aw_addr_d     = aw_addr_q;
    w_held_d      = w_held_q;
    w_data_d      = w_data_q;
    ar_held_d     = ar_held_q;
    ar_addr_d     = ar_addr_q;
    last_wr_d     = last_wr_q;
    bresp_d       = bresp_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    start_d       = 1'b0;
    busy_d        = busy_q;
    input_addr_d  = input_addr_q;
    weight_addr_d = weight_addr_q;
    output_addr_d = output_addr_q;
    dim_m_d       = dim_m_q;
    dim_k_d       = dim_k_q;
    dim_n_d       = dim_n_q;
    done_set      = 1'b0;
    done_clr      = 1'b0;
    wr_go         = aw_held_q && w_held_q;
    rd_go         = ar_held_q;
    // A write wins contention unless the previous service was itself a write.
    pick_wr       = wr_go && (!rd_go || !last_wr_q);

    if (awvalid && awready_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = awaddr;
    end
    if (wvalid && wready_q) begin
      w_held_d = 1'b1;
      w_data_d = wdata;
    end
    if (arvalid && arready_q) begin
      ar_held_d = 1'b1;
      ar_addr_d = araddr;
    end
    if (matmul_finished && busy_q) begin
      busy_d   = 1'b0;
      done_set = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_wr) begin
          last_wr_d = 1'b1;
          if (aw_addr_q[ADDR_W-1]) begin
            state_d = BRESP;
            bresp_d = SLVERR;
            case (wr_off)
              CSR_INPUT:  if (!busy_q) begin input_addr_d  = ADDR_W'(w_data_q); bresp_d = OKAY; end
              CSR_WEIGHT: if (!busy_q) begin weight_addr_d = ADDR_W'(w_data_q); bresp_d = OKAY; end
              CSR_OUTPUT: if (!busy_q) begin output_addr_d = ADDR_W'(w_data_q); bresp_d = OKAY; end
              CSR_DIMS: if (!busy_q) begin
                dim_m_d = w_data_q[DIM_W-1:0];
                dim_k_d = w_data_q[2*DIM_W-1:DIM_W];
                dim_n_d = w_data_q[3*DIM_W-1:2*DIM_W];
                bresp_d = OKAY;
              end
              CSR_CTRL: if (!busy_q) begin
                bresp_d = OKAY;
                if (w_data_q[0]) begin
                  start_d  = 1'b1;
                  busy_d   = 1'b1;
                  done_clr = 1'b1;
                end
              end
              default: ;
            endcase
          end else begin
            state_d = SC_WR;
          end
        end else if (rd_go) begin
          last_wr_d = 1'b0;
          if (ar_addr_q[ADDR_W-1]) begin
            state_d = RRESP;
            rresp_d = OKAY;
            rdata_d = '0;
            case (rd_off)
              CSR_INPUT:  rdata_d = DATA_W'(input_addr_q);
              CSR_WEIGHT: rdata_d = DATA_W'(weight_addr_q);
              CSR_OUTPUT: rdata_d = DATA_W'(output_addr_q);
              CSR_DIMS:   rdata_d = DATA_W'({dim_n_q, dim_k_q, dim_m_q});
              CSR_CTRL:   rdata_d = '0;
              CSR_STATUS: begin
                rdata_d  = DATA_W'({done_q, busy_q});
                done_clr = 1'b1;
              end
              default:    rresp_d = SLVERR;
            endcase
          end else begin
            state_d = SC_RD;
          end
        end
      end
      SC_WR: if (sc_ready) begin
        bresp_d = OKAY;
        state_d = BRESP;
      end
      SC_RD: if (sc_ready) begin
        rdata_d = sc_rdata;
        rresp_d = OKAY;
        state_d = RRESP;
      end
      BRESP: if (bready) begin
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        state_d   = IDLE;
      end
      RRESP: if (rready) begin
        ar_held_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A completion landing with a STATUS read keeps done set.
    done_d = done_set ? 1'b1 : (done_clr ? 1'b0 : done_q);

    awready_d = (state_d == IDLE) && !aw_held_d;
    wready_d  = (state_d == IDLE) && !w_held_d;
    arready_d = (state_d == IDLE) && !ar_held_d;
    bvalid_d  = (state_d == BRESP);
    rvalid_d  = (state_d == RRESP);
    sc_req_d  = (state_d == SC_WR) || (state_d == SC_RD);
    sc_we_d   = (state_d == SC_WR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      aw_held_q     <= 1'b0;
      aw_addr_q     <= '0;
      w_held_q      <= 1'b0;
      w_data_q      <= '0;
      ar_held_q     <= 1'b0;
      ar_addr_q     <= '0;
      last_wr_q     <= 1'b0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      arready_q     <= 1'b0;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      bresp_q       <= OKAY;
      rresp_q       <= OKAY;
      rdata_q       <= '0;
      sc_req_q      <= 1'b0;
      sc_we_q       <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      input_addr_q  <= '0;
      weight_addr_q <= '0;
      output_addr_q <= '0;
      dim_m_q       <= '0;
      dim_k_q       <= '0;
      dim_n_q       <= '0;
    end else begin
      state_q       <= state_d;
      aw_held_q     <= aw_held_d;
      aw_addr_q     <= aw_addr_d;
      w_held_q      <= w_held_d;
      w_data_q      <= w_data_d;
      ar_held_q     <= ar_held_d;
      ar_addr_q     <= ar_addr_d;
      last_wr_q     <= last_wr_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      arready_q     <= arready_d;
      bvalid_q      <= bvalid_d;
      rvalid_q      <= rvalid_d;
      bresp_q       <= bresp_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      sc_req_q      <= sc_req_d;
      sc_we_q       <= sc_we_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      input_addr_q  <= input_addr_d;
      weight_addr_q <= weight_addr_d;
      output_addr_q <= output_addr_d;
      dim_m_q       <= dim_m_d;
      dim_k_q       <= dim_k_d;
      dim_n_q       <= dim_n_d;
    end
  end

  assign awready      = awready_q;
  assign wready       = wready_q;
  assign arready      = arready_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign sc_req       = sc_req_q;
  assign sc_we        = sc_we_q;
  assign sc_addr      = sc_we_q ? aw_addr_q[SC_ADDR_W-1:0] : ar_addr_q[SC_ADDR_W-1:0];
  assign sc_wdata     = w_data_q;
  assign start_matmul = start_q;
  assign input_addr   = input_addr_q;
  assign weight_addr  = weight_addr_q;
  assign output_addr  = output_addr_q;
  assign dim_m        = dim_m_q;
  assign dim_k        = dim_k_q;
  assign dim_n        = dim_n_q;

endmodule

// File: tb/tb_sa_axil_controller.sv
// Directed bench for sa_axil_controller: stimulus pushes expected AXI responses and scratchpad
// requests into queues that independent monitors drain and compare.
module tb_sa_axil_controller;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0, rst = 1'b1;
  logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        sc_req, sc_we, sc_ready = 0;
  logic [15:0] sc_addr;
  logic [31:0] sc_wdata, sc_rdata = 0;
  logic        start_matmul, matmul_finished = 0;
  logic [31:0] input_addr, weight_addr, output_addr;
  logic [7:0]  dim_m, dim_k, dim_n;

  always #5 clk = ~clk;

  sa_axil_controller dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .sc_req(sc_req), .sc_we(sc_we), .sc_addr(sc_addr), .sc_wdata(sc_wdata),
    .sc_rdata(sc_rdata), .sc_ready(sc_ready),
    .start_matmul(start_matmul),
    .input_addr(input_addr), .weight_addr(weight_addr), .output_addr(output_addr),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .matmul_finished(matmul_finished)
  );

  typedef struct { bit is_rd; logic [1:0] resp; logic [31:0] data; } rsp_t;
  typedef struct { bit we; logic [15:0] addr; logic [31:0] wdata; } sc_t;

  rsp_t        rsp_q[$];
  sc_t         sc_q[$];
  int          n_tests = 0, n_fail = 0;
  int          start_cnt = 0, sc_cnt = 0, sc_delay = 0;
  logic [31:0] mem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Response monitor: every B or R handshake must match the oldest expectation, kind included.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && ((bvalid && bready) || (rvalid && rready))) begin
      if (rsp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: bvalid=%0b rvalid=%0b with nothing expected", bvalid, rvalid);
      end else begin
        e = rsp_q.pop_front();
        check("resp_kind", 32'(rvalid), 32'(e.is_rd));
        if (e.is_rd) begin
          check("rresp", 32'(rresp), 32'(e.resp));
          check("rdata", rdata, e.data);
        end else begin
          check("bresp", 32'(bresp), 32'(e.resp));
        end
      end
    end
  end

  always @(negedge clk) if (!rst && start_matmul) start_cnt++;

  // Scratchpad model: checks each new request, completes it sc_delay cycles later.
  always @(negedge clk) begin
    sc_t e;
    if (rst) begin
      sc_ready = 1'b0;
      sc_cnt   = 0;
    end else if (sc_ready) begin
      sc_ready = 1'b0;
      sc_cnt   = 0;
    end else if (sc_req) begin
      if (sc_cnt == 0) begin
        if (sc_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_sc_req: we=%0b addr=0x%04h", sc_we, sc_addr);
        end else begin
          e = sc_q.pop_front();
          check("sc_we", 32'(sc_we), 32'(e.we));
          check("sc_addr", 32'(sc_addr), 32'(e.addr));
          if (e.we) check("sc_wdata", sc_wdata, e.wdata);
        end
      end
      if (sc_cnt >= sc_delay) begin
        sc_ready = 1'b1;
        if (sc_we) mem[sc_addr[7:0]] = sc_wdata;
        else       sc_rdata = mem[sc_addr[7:0]];
      end
      sc_cnt++;
    end
  end

  task automatic do_aw(input logic [31:0] a);
    bit ok = 0;
    awaddr = a;
    awvalid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = awready; end
    if (!ok) timeout("aw_handshake");
    @(posedge clk); #1 awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] d);
    bit ok = 0;
    wdata = d;
    wvalid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = wready; end
    if (!ok) timeout("w_handshake");
    @(posedge clk); #1 wvalid = 0;
  endtask

  task automatic do_ar(input logic [31:0] a);
    bit ok = 0;
    araddr = a;
    arvalid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = arready; end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1 arvalid = 0;
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = (rsp_q.size() == 0); end
    if (!ok) timeout("response_drain");
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    rsp_q.push_back(rsp_t'{1'b0, resp, 32'h0});
    fork
      do_aw(a);
      do_w(d);
    join
    wait_rsp();
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] d);
    rsp_q.push_back(rsp_t'{1'b1, resp, d});
    do_ar(a);
    wait_rsp();
  endtask

  initial begin
    int  s0;
    bit  ok;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_valids", 32'({bvalid, rvalid, sc_req, sc_we, start_matmul}), 0);
    check("rst_resps", 32'({bresp, rresp}), 0);
    check("rst_input_addr", input_addr, 0);
    check("rst_dims", 32'({dim_n, dim_k, dim_m}), 0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // CSR writes, first one with a latency check
    rsp_q.push_back(rsp_t'{1'b0, OKAY, 32'h0});
    fork
      do_aw(32'h8000_0000);
      do_w(32'h0000_1000);
    join
    check("csr_wr_bvalid_early", 32'(bvalid), 0);
    @(posedge clk); #1;
    check("csr_wr_bvalid_lat2", 32'(bvalid), 1);
    wait_rsp();
    axi_write(32'h8000_0001, 32'h0000_2000, OKAY);
    axi_write(32'h8000_0002, 32'h0000_3000, OKAY);
    axi_write(32'h8000_0003, 32'h0004_0404, OKAY);
    check("input_addr", input_addr, 32'h1000);
    check("weight_addr", weight_addr, 32'h2000);
    check("output_addr", output_addr, 32'h3000);
    check("dim_m", 32'(dim_m), 4);
    check("dim_k", 32'(dim_k), 4);
    check("dim_n", 32'(dim_n), 4);
    axi_read(32'h8000_0003, OKAY, 32'h0004_0404);

    // Scratchpad write, W ahead of AW, B held off by bready
    sc_delay = 0;
    sc_q.push_back(sc_t'{1'b1, 16'h0010, 32'hDEADBEEF});
    rsp_q.push_back(rsp_t'{1'b0, OKAY, 32'h0});
    bready = 0;
    fork
      do_w(32'hDEADBEEF);
      begin repeat (3) @(posedge clk); #1; do_aw(32'h0000_0010); end
    join
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = bvalid; end
    if (!ok) timeout("sc_wr_bvalid");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bvalid_held", 32'(bvalid), 1);
      check("awready_blocked", 32'(awready), 0);
    end
    @(posedge clk); #1 bready = 1;
    wait_rsp();

    // Scratchpad read with late completion, R held off by rready
    sc_delay = 3;
    sc_q.push_back(sc_t'{1'b0, 16'h0010, 32'h0});
    rsp_q.push_back(rsp_t'{1'b1, OKAY, 32'hDEADBEEF});
    rready = 0;
    do_ar(32'h0000_0010);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(posedge clk); ok = sc_ready; end
    if (!ok) timeout("sc_rd_ready");
    #1;
    check("sc_rd_rvalid_next", 32'(rvalid), 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("rvalid_held", 32'(rvalid), 1);
      check("rdata_held", rdata, 32'hDEADBEEF);
    end
    rready = 1;
    wait_rsp();
    sc_delay = 0;

    // Start / busy / done
    s0 = start_cnt;
    axi_write(32'h8000_0004, 32'h1, OKAY);
    check("start_pulse_count", 32'(start_cnt - s0), 1);
    axi_read(32'h8000_0005, OKAY, 32'h1);
    axi_write(32'h8000_0000, 32'h5555, SLVERR);
    check("input_addr_kept", input_addr, 32'h1000);
    axi_write(32'h8000_0004, 32'h1, SLVERR);
    check("no_extra_start", 32'(start_cnt - s0), 1);
    matmul_finished = 1;
    @(posedge clk); #1 matmul_finished = 0;
    axi_read(32'h8000_0005, OKAY, 32'h2);
    axi_read(32'h8000_0005, OKAY, 32'h0);

    // Completion coincident with a STATUS read
    axi_write(32'h8000_0004, 32'h1, OKAY);
    check("second_start", 32'(start_cnt - s0), 2);
    rsp_q.push_back(rsp_t'{1'b1, OKAY, 32'h1});
    do_ar(32'h8000_0005);
    matmul_finished = 1;
    @(posedge clk); #1 matmul_finished = 0;
    wait_rsp();
    axi_read(32'h8000_0005, OKAY, 32'h2);
    axi_read(32'h8000_0005, OKAY, 32'h0);

    // Contending write/read: previous service was a read, so write goes first each round
    for (int r = 0; r < 3; r++) begin
      sc_q.push_back(sc_t'{1'b1, 16'(32'h20 + r), 32'hA000_0000 + r});
      rsp_q.push_back(rsp_t'{1'b0, OKAY, 32'h0});
      rsp_q.push_back(rsp_t'{1'b1, OKAY, 32'h0});
      fork
        do_aw(32'h20 + r);
        do_w(32'hA000_0000 + r);
        do_ar(32'h8000_0005);
      join
      wait_rsp();
    end

    // Unmapped CSR
    axi_read(32'h8000_000F, SLVERR, 32'h0);
    axi_write(32'h8000_000F, 32'h1234, SLVERR);

    // Reset while parked in SC_RD
    sc_delay = 40;
    sc_q.push_back(sc_t'{1'b0, 16'h0030, 32'h0});
    do_ar(32'h0000_0030);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = sc_req; end
    if (!ok) timeout("sc_rd_req");
    #1 rst = 1;
    #1;
    check("rst_mid_rvalid", 32'(rvalid), 0);
    check("rst_mid_sc_req", 32'(sc_req), 0);
    check("rst_mid_input_addr", input_addr, 0);
    check("rst_mid_weight_addr", weight_addr, 0);
    check("rst_mid_output_addr", output_addr, 0);
    check("rst_mid_dims", 32'({dim_n, dim_k, dim_m}), 0);
    @(posedge clk); #1 rst = 0;
    sc_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    axi_read(32'h8000_0005, OKAY, 32'h0);

    repeat (5) @(posedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 0);
    check("sc_queue_drained", 32'(sc_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sa_axil_controller.md
Name: sa_axil_controller

Overview:
- Parametrised AXI4-Lite slave front-end for the systolic array. It replaces the single-cycle-decode host controller.
- Accepts independent AW/W channels and returns B responses. Provides a full R handshake.
- Routes accesses either to the scratchpad or to an internal CSR bank: operand base addresses, matrix dimensions, start and status.
- Issues a one-cycle matmul start pulse and tracks busy/done.

Parameters:
- ADDR_W, 32, AXI address width (word addresses).
- DATA_W, 32, AXI/scratchpad data width.
- SC_ADDR_W, 16, scratchpad address width; the low SC_ADDR_W bits of the AXI address are used.
- DIM_W, 8, width of each matrix dimension field.

Ports:
- clk in 1: clock.
- rst in 1: asynchronous active-high reset.
- awvalid in 1, awaddr in ADDR_W, awready out 1: write address channel.
- wvalid in 1, wdata in DATA_W, wready out 1: write data channel.
- bvalid out 1, bresp out 2, bready in 1: write response channel.
- arvalid in 1, araddr in ADDR_W, arready out 1: read address channel.
- rvalid out 1, rdata out DATA_W, rresp out 2, rready in 1: read data channel.
- sc_req out 1, sc_we out 1, sc_addr out SC_ADDR_W, sc_wdata out DATA_W: scratchpad request.
- sc_rdata in DATA_W, sc_ready in 1: scratchpad completion (read data valid with sc_ready).
- start_matmul out 1: one-cycle start pulse.
- input_addr, weight_addr, output_addr out ADDR_W: operand base registers.
- dim_m, dim_k, dim_n out DIM_W: matrix dimensions.
- matmul_finished in 1: one-cycle completion pulse from the array.

Behaviour:
- Address decode: awaddr/araddr[ADDR_W-1]=1 selects CSR (offset = addr[3:0]); 0 selects scratchpad.
- CSR map:
  - 0x0 input_addr (RW), 0x1 weight_addr (RW), 0x2 output_addr (RW).
  - 0x3 DIMS (RW): {dim_n, dim_k, dim_m} packed from bit 0.
  - 0x4 CTRL (W): bit0=1 starts; reads 0.
  - 0x5 STATUS (RO): bit0 busy, bit1 done (sticky, cleared by reading STATUS).
  - Other offsets: reads return 0 with rresp=SLVERR; writes are dropped with bresp=SLVERR.
- Reset: all CSRs 0, busy=0, done=0, state IDLE. All valids, readies, sc_req, sc_we and start_matmul are 0; bresp/rresp are 0.
- Write path:
  - awready and wready are asserted independently in IDLE when the corresponding holding register is empty. Each beat is latched on its handshake.
  - The write executes only when both address and data are held.
- Read path: arready is asserted in IDLE when no read is in progress; araddr is latched on the handshake.
- FSM states: IDLE, SC_WR, SC_RD, BRESP, RRESP.
  - IDLE, both write halves held:
    - CSR target: write CSR, then BRESP next cycle.
    - Scratchpad target: go to SC_WR.
  - IDLE, read address held:
    - CSR target: load rdata, then RRESP.
    - Scratchpad target: go to SC_RD.
  - IDLE, both a write and a read ready in the same cycle: round-robin; the op type not served last wins; the first arbitration after reset favours write.
  - SC_WR: sc_req=1, sc_we=1, sc_addr/sc_wdata held. On sc_ready, go to BRESP.
  - SC_RD: sc_req=1, sc_we=0. On sc_ready, capture sc_rdata and go to RRESP.
  - BRESP: bvalid=1 until bready; then clear the write holds and return to IDLE.
  - RRESP: rvalid=1, rdata/rresp stable until rready; then return to IDLE.
- Latency:
  - CSR write: bvalid 2 cycles after the later of the AW/W handshakes.
  - CSR read: rvalid 2 cycles after the AR handshake.
  - Scratchpad access: the cycle after sc_ready.
- Busy handling:
  - A CTRL write with busy=0 pulses start_matmul for exactly 1 cycle (the cycle after the CSR write), sets busy=1 and clears done.
  - A CTRL write while busy=1 is ignored, with bresp=SLVERR.
  - Writes to offsets 0x0–0x3 while busy=1 are dropped, with bresp=SLVERR. Scratchpad accesses are allowed while busy.
- matmul_finished while busy=1: busy<=0 and done<=1 in that cycle.
  - If it coincides with a STATUS read, the read returns the pre-update value and done ends at 1; set wins over clear.
  - matmul_finished while busy=0 is ignored.
- Reset mid-transaction: all held beats and pending responses are discarded and the state returns to IDLE. The array must be reset alongside.

Test Plan:
- Reset then write 0x80000000←0x1000, 0x80000001←0x2000, 0x80000002←0x3000, 0x80000003←0x00040404 → each bresp=OKAY; input/weight/output_addr=0x1000/0x2000/0x3000; dim_m=dim_k=dim_n=4.
- W beat 0xDEADBEEF presented 3 cycles before AW 0x00000010 → single sc_req with sc_we=1, sc_addr=0x0010, sc_wdata=0xDEADBEEF. bvalid follows sc_ready; bready held low 4 cycles → bvalid stays high and no new awready.
- Scratchpad read of 0x0010 with sc_ready returned 3 cycles late and sc_rdata=0xDEADBEEF → rvalid the cycle after sc_ready, rdata=0xDEADBEEF, rresp=OKAY, held until rready.
- Write CTRL=1 → start_matmul high for exactly 1 cycle, STATUS=0x1. Then write 0x80000000 and CTRL while busy → SLVERR, input_addr unchanged, no extra pulse. Pulse matmul_finished → STATUS read 0x2, next STATUS read 0x0.
- Simultaneous AW/W to the scratchpad and AR to CSR 0x5 for 3 consecutive transactions → service order alternates write, read, write; no lost responses.
- Read CSR 0xF → rdata=0, rresp=SLVERR. Assert rst while in SC_RD → rvalid=0, sc_req=0 immediately, all CSRs 0.
